// File: rtl/scope_capture_if.sv
// rtl/scope_capture_if.sv - register bus, sample stream and buffer-write bundle for scope_capture_ctrl
interface scope_capture_if #(
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 9
);
    logic [15:0]         writedata;
    logic                write;
    logic                chipselect;
    logic [2:0]          address;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                frame_done;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic [ADDR_W-1:0]   trig_addr;
    logic                armed;
    logic                capture_done;

    modport master (
        output writedata, write, chipselect, address, sample_in, sample_valid, frame_done,
        input  wr_en, wr_addr, wr_data, trig_addr, armed, capture_done
    );

    modport slave (
        input  writedata, write, chipselect, address, sample_in, sample_valid, frame_done,
        output wr_en, wr_addr, wr_data, trig_addr, armed, capture_done
    );
endinterface

// File: rtl/scope_capture_ctrl.sv
// rtl/scope_capture_ctrl.sv - decimating pre/post-trigger capture sequencer feeding a circular sample buffer
module scope_capture_ctrl #(
    parameter int SAMPLE_W     = 12,
    parameter int ADDR_W       = 9,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input logic            clk,
    input logic            reset,
    scope_capture_if.slave bus
);
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(AUTO_TIMEOUT);
    localparam logic [SAMPLE_W-1:0] LEVEL_RST = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0]   PRE_RST   = {1'b1, {(ADDR_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
    state_t state, state_next;

    logic [SAMPLE_W-1:0] level;
    logic                rising, auto_mode, single;
    logic [15:0]         decim, decim_lat, dec_cnt;
    logic [ADDR_W-1:0]   pre, pre_lat, phase_cnt, wr_ptr;
    logic [SAMPLE_W-1:0] prev;
    logic                prev_valid, force_pend;
    logic [TO_W-1:0]     to_cnt;

    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q, trig_addr_q;
    logic [SAMPLE_W-1:0] wr_data_q;

    logic reg_wr, ctrl_wr, force_wr, capturing, post_full, dec_hit;
    logic accept, edge_hit, timeout_hit, trigger;
    logic [ADDR_W-1:0] post_len;

    assign reg_wr   = bus.write & bus.chipselect;
    assign ctrl_wr  = reg_wr && (bus.address == 3'd1);
    assign force_wr = reg_wr && (bus.address == 3'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level     <= LEVEL_RST;
            rising    <= 1'b1;
            auto_mode <= 1'b0;
            single    <= 1'b0;
            decim     <= '0;
            pre       <= PRE_RST;
        end else if (reg_wr) begin
            case (bus.address)
                3'd0: level <= bus.writedata[SAMPLE_W-1:0];
                3'd1: begin
                    rising    <= bus.writedata[0];
                    auto_mode <= bus.writedata[1];
                    single    <= bus.writedata[2];
                end
                3'd2: decim <= bus.writedata;
                3'd3: pre   <= bus.writedata[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    // post_len is DEPTH-1-pre: the trigger sample plus pre history already occupy the rest
    assign post_len    = ~pre_lat;
    assign capturing   = (state == PRE) || (state == ARMED) || (state == POST);
    assign post_full   = (state == POST) && (phase_cnt == post_len);
    assign dec_hit     = (dec_cnt == decim_lat);
    assign accept      = bus.sample_valid && dec_hit && capturing && !post_full && !ctrl_wr;
    assign edge_hit    = prev_valid && (rising ? (prev < level && bus.sample_in >= level)
                                               : (prev > level && bus.sample_in <= level));
    assign timeout_hit = auto_mode && (to_cnt == TO_LAST);
    assign trigger     = accept && (state == ARMED) && (edge_hit || force_pend || timeout_hit);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (pre == '0) ? ARMED : PRE;
            PRE:     if (accept && (phase_cnt == pre_lat - ADDR_W'(1))) state_next = ARMED;
            ARMED:   if (trigger) state_next = POST;
            POST:    if (post_full) state_next = DONE;
            DONE:    if (bus.frame_done && !single) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (ctrl_wr) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            decim_lat   <= '0;
            pre_lat     <= '0;
            dec_cnt     <= '0;
            phase_cnt   <= '0;
            wr_ptr      <= '0;
            prev        <= '0;
            prev_valid  <= 1'b0;
            force_pend  <= 1'b0;
            to_cnt      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            trig_addr_q <= '0;
        end else begin
            state   <= state_next;
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q  <= wr_ptr;
                wr_data_q  <= bus.sample_in;
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                prev       <= bus.sample_in;
                prev_valid <= 1'b1;
            end

            if (state == IDLE) begin
                decim_lat  <= decim;
                pre_lat    <= pre;
                dec_cnt    <= '0;
                phase_cnt  <= '0;
                prev_valid <= 1'b0;
            end else begin
                if (bus.sample_valid && capturing)
                    dec_cnt <= dec_hit ? '0 : dec_cnt + 16'd1;
                if (trigger)
                    phase_cnt <= '0;
                else if (accept && (state == PRE || state == POST))
                    phase_cnt <= phase_cnt + ADDR_W'(1);
            end

            if (trigger) trig_addr_q <= wr_ptr;

            // timeout and pending force only live while ARMED; both restart on every entry
            if (state != ARMED) begin
                to_cnt     <= '0;
                force_pend <= 1'b0;
            end else begin
                if (to_cnt != TO_LAST) to_cnt <= to_cnt + TO_W'(1);
                if (force_wr) force_pend <= 1'b1;
            end
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.trig_addr    = trig_addr_q;
    assign bus.armed        = (state == ARMED);
    assign bus.capture_done = (state == DONE);
endmodule
